// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte-strobe input and serial/status output bundle for uart_tx_fifo
interface uart_tx_fifo_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic       tx_done;

  modport master (
    output pi_data,
    output pi_flag,
    input  tx,
    input  busy,
    input  fifo_full,
    input  overflow,
    input  tx_done
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output tx,
    output busy,
    output fifo_full,
    output overflow,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with back-to-back frames
module uart_tx_fifo #(
  parameter int UART_BPS   = 10_000_000,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_tx_fifo_if.slave bus
);

  localparam int BAUD_MAX = CLK_FREQ / UART_BPS;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W   = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_MAX - 1);

  generate
    if (BAUD_MAX < 2) begin : g_baud_check
      $error("uart_tx_fifo: CLK_FREQ/UART_BPS must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shift, shift_n;
  logic              tx_r, tx_n;
  logic              done_r, done_n;
  logic              pop;
  logic              baud_last;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_n;
  logic              wr_en;
  logic              busy_r, full_r, ovf_r;

  // A byte is only accepted against the registered occupancy, so a pop in the
  // same cycle never frees room for a strobe that arrives while full.
  assign wr_en = bus.pi_flag && (count != DEPTH_C);

  // Next-state, counters, shifter and line value for the frame sequencer
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    pop       = 1'b0;
    baud_last = (baud_cnt == BAUD_LAST);
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (count != '0) begin
            // Chain straight into the next start bit so queued bytes leave gap-free
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            bit_n   = '0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The line register follows the state being entered, keeping tx glitch-free
    unique case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST);
  end

  // Occupancy after this cycle's accepted write and/or pop
  always_comb begin
    count_n = count;
    unique case ({wr_en, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // Sequencer state register and registered line outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx_r     <= tx_n;
      done_r   <= done_n;
    end
  end

  // FIFO pointers, occupancy and registered status flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      full_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count  <= count_n;
      busy_r <= (state_n != S_IDLE) || (count_n != '0);
      full_r <= (count_n == DEPTH_C);
      if (bus.pi_flag && !wr_en) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Byte storage; contents need no reset because count gates every read
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.pi_data;
    end
  end

  assign bus.tx        = tx_r;
  assign bus.busy      = busy_r;
  assign bus.fifo_full = full_r;
  assign bus.overflow  = ovf_r;
  assign bus.tx_done   = done_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a queue/timeline reference model
module tb_uart_tx_fifo;

  localparam int B     = 50_000_000 / 10_000_000;
  localparam int FRAME = 10 * B;
  localparam int DEPTH = 16;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  uart_tx_fifo_if bus ();

  uart_tx_fifo dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes waiting in the queue plus the edge at which the line frees up
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int  edge_no   = 0;
  int  next_free = 0;
  int  n_pops    = 0;
  bit  m_ovf     = 1'b0;

  // Monitor bookkeeping
  int neg_cnt     = 0;
  int first_start = -1;
  int last_end    = -1;
  int frames_seen = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_busy();
    return (mq.size() != 0) || (edge_no < next_free);
  endfunction

  task automatic model_edge(input bit f, input logic [7:0] d);
    int  pre;
    bit  acc;
    edge_no++;
    pre = mq.size();
    acc = f && (pre < DEPTH);
    if (f && !acc) m_ovf = 1'b1;
    if (pre > 0 && edge_no >= next_free) begin
      void'(mq.pop_front());
      next_free = edge_no + FRAME;
      n_pops++;
    end
    if (acc) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  task automatic cyc(input bit f, input logic [7:0] d);
    bus.pi_flag = f;
    bus.pi_data = d;
    @(posedge sys_clk);
    model_edge(f, d);
    #1;
    bus.pi_flag = 1'b0;
    check("status_busy_full_ovf", {29'd0, bus.busy, bus.fifo_full, bus.overflow},
          {29'd0, model_busy(), (mq.size() == DEPTH), m_ovf});
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    bus.pi_flag = 1'b0;
    @(posedge sys_clk);
    edge_no++;
    mq.delete();
    exp_q.delete();
    next_free = 0;
    m_ovf     = 1'b0;
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (model_busy() && budget < 5000) begin
      cyc(1'b0, 8'h00);
      budget++;
    end
    check("drain_within_budget", {31'd0, model_busy()}, 32'd0);
    repeat (3) cyc(1'b0, 8'h00);
  endtask

  // Frame monitor: decodes tx at negedges and compares against the scoreboard queue
  initial begin
    int         m_cyc;
    bit         m_act;
    bit         glitch;
    bit         derr;
    logic [9:0] bits;
    logic [7:0] eb;
    int         bi;
    m_cyc = 0; m_act = 0; glitch = 0; derr = 0; bits = '0;
    forever begin
      @(negedge sys_clk);
      neg_cnt++;
      if (sys_rst) begin
        m_act = 0;
      end else begin
        if (!m_act) begin
          if (bus.tx_done === 1'b1) check("tx_done_outside_frame", 32'd1, 32'd0);
          if (bus.tx === 1'b0) begin
            m_act = 1; m_cyc = 0; glitch = 0; derr = 0; bits = '0;
            if (first_start < 0) first_start = neg_cnt;
          end
        end
        if (m_act) begin
          bi = m_cyc / B;
          if (m_cyc % B == 0) bits[bi] = bus.tx;
          else if (bus.tx !== bits[bi]) glitch = 1;
          if (bus.tx_done !== (m_cyc == FRAME - 1)) derr = 1;
          if (m_cyc == FRAME - 1) begin
            check("frame_start_stop_glitch", {29'd0, glitch, bits[0], bits[9]}, 32'b001);
            check("tx_done_last_stop_cycle", {31'd0, derr}, 32'd0);
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_frame: got byte %02h, expected no frame", bits[8:1]);
            end else begin
              eb = exp_q.pop_front();
              check("frame_byte", {24'd0, bits[8:1]}, {24'd0, eb});
            end
            frames_seen++;
            last_end = neg_cnt;
            m_act = 0;
          end else begin
            m_cyc++;
          end
        end
      end
    end
  end

  initial begin
    int f0;
    int budget;
    logic [7:0] lb [4];
    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    lb[0] = 8'hFF; lb[1] = 8'h00; lb[2] = 8'h3C; lb[3] = 8'h81;

    do_reset();
    #1;
    check("reset_outputs", {27'd0, bus.tx, bus.busy, bus.fifo_full, bus.overflow, bus.tx_done},
          32'b10000);

    // Single byte from idle: tx falls two edges after the strobe
    cyc(1'b1, 8'hA5);
    check("latency_tx_high_after_e0", {31'd0, bus.tx}, 32'd1);
    cyc(1'b0, 8'h00);
    check("latency_tx_low_after_e1", {31'd0, bus.tx}, 32'd0);
    drain();

    // 16 back-to-back strobes: contiguous frames, never full
    first_start = -1;
    f0 = frames_seen;
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i));
    drain();
    check("burst16_frame_count", frames_seen - f0, 32'd16);
    check("burst16_span_cycles", last_end - first_start + 1, 32'(16 * FRAME));
    check("burst16_no_overflow", {31'd0, bus.overflow}, 32'd0);

    // 18 strobes: 17 accepted, the last dropped, overflow sticky
    for (int i = 0; i < 18; i++) cyc(1'b1, 8'(i));
    check("burst18_full", {31'd0, bus.fifo_full}, 32'd1);
    check("burst18_overflow", {31'd0, bus.overflow}, 32'd1);
    budget = 0;
    while (!(mq.size() == DEPTH && edge_no + 1 >= next_free) && budget < 200) begin
      cyc(1'b0, 8'h00);
      budget++;
    end
    check("full_pop_window_reached", {31'd0, (budget < 200)}, 32'd1);
    check("full_before_pop", {31'd0, bus.fifo_full}, 32'd1);
    cyc(1'b1, 8'hEE);
    check("full_drop_with_pop_count15", {31'd0, bus.fifo_full}, 32'd0);
    drain();
    check("overflow_sticky_after_drain", {31'd0, bus.overflow}, 32'd1);

    // Reset during data bit 3 of the second queued frame
    do_reset();
    n_pops = 0;
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    cyc(1'b1, 8'h33);
    budget = 0;
    while (n_pops < 2 && budget < 200) begin
      cyc(1'b0, 8'h00);
      budget++;
    end
    repeat (21) cyc(1'b0, 8'h00);
    do_reset();
    #1;
    check("midframe_reset_outputs",
          {27'd0, bus.tx, bus.busy, bus.fifo_full, bus.overflow, bus.tx_done}, 32'b10000);
    f0 = frames_seen;
    repeat (3 * FRAME) cyc(1'b0, 8'h00);
    check("no_frames_after_reset", frames_seen - f0, 32'd0);

    // Loopback bytes at random spacing, then random traffic with occasional bursts
    f0 = frames_seen;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 80)) cyc(1'b0, 8'h00);
      cyc(1'b1, lb[i]);
    end
    drain();
    check("loopback_frame_count", frames_seen - f0, 32'd4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        for (int j = 0; j < 20; j++) cyc(1'b1, 8'($urandom));
      end else begin
        cyc(($urandom_range(0, 29) == 0), 8'($urandom));
      end
    end
    drain();
    check("scoreboard_empty_at_end", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
